// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage between EX and WB.
// Holds one instruction, waits for the data_sram response of a load/store,
// extracts and extends load data, and hands result, regfile write info and
// exception vector to WB. Responses belonging to requests killed by a WB
// flush are counted and silently dropped.
// Optional feature macro: MS_LOAD_FWD_EN (early forwarding of load data to ID).
module mem_stage #(
  parameter int EXC_W  = 16,
  parameter int LDOP_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [31:0]       es_pc,
  input  logic              es_res_from_mem,
  input  logic              es_rf_we,
  input  logic [4:0]        es_rf_waddr,
  input  logic [31:0]       es_result,
  input  logic [LDOP_W-1:0] es_ld_op,
  input  logic              es_mem_req,
  input  logic [EXC_W-1:0]  es_except,
  input  logic              es_req_fire,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              ws_allowin,
  input  logic              except_flush,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic              ms_rf_we,
  output logic [4:0]        ms_rf_waddr,
  output logic [31:0]       ms_final_result,
  output logic [EXC_W-1:0]  ms_except,
  output logic              ms_ex,
  output logic              ms_fwd_ready
);

  // ld_op one-hot bit positions: {ld_w, ld_h, ld_hu, ld_b, ld_bu}
  localparam int LD_W  = 4;
  localparam int LD_H  = 3;
  localparam int LD_HU = 2;
  localparam int LD_B  = 1;
  localparam int LD_BU = 0;

  // stage state
  logic              ms_valid_q, ms_valid_d;
  logic [31:0]       ms_pc_q;
  logic              ms_res_from_mem_q;
  logic              ms_rf_we_q;
  logic [4:0]        ms_rf_waddr_q;
  logic [31:0]       ms_result_q;
  logic [LDOP_W-1:0] ms_ld_op_q;
  logic              ms_mem_req_q;
  logic [EXC_W-1:0]  ms_except_q;

  // response bookkeeping
  logic [1:0]        cancel_cnt_q, cancel_cnt_d;
  logic              buf_valid_q, buf_valid_d;
  logic [31:0]       buf_rdata_q, buf_rdata_d;

  logic              load_en;
  logic              retire;
  logic              resp_ok;
  logic              ready_go;
  logic              mem_pending;
  logic              cancel_dec;
  logic [2:0]        cancel_inc;
  logic [2:0]        cancel_nxt;

  logic [31:0]       ld_src;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_data;

  // A response only belongs to the current instruction once every
  // cancelled request ahead of it has drained.
  assign resp_ok  = data_sram_data_ok & (cancel_cnt_q == 2'd0);

  assign ms_except = ms_except_q & {EXC_W{ms_valid_q}};
  assign ms_ex     = |ms_except;

  // An excepting entry never issued a request, so it need not wait.
  assign ready_go  = ~ms_mem_req_q | ms_ex | buf_valid_q | resp_ok;

  assign ms_allowin     = ~ms_valid_q | (ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ready_go;
  assign load_en        = es_to_ms_valid & ms_allowin;
  assign retire         = ms_to_ws_valid & ws_allowin;

  assign ms_pc       = ms_pc_q;
  assign ms_rf_waddr = ms_rf_waddr_q;
  assign ms_rf_we    = ms_rf_we_q & ms_valid_q & ~ms_ex;

  // MEM still owes a response for its own request (not yet seen or buffered).
  assign mem_pending = ms_valid_q & ms_mem_req_q & ~buf_valid_q & ~resp_ok;
  assign cancel_dec  = data_sram_data_ok & (cancel_cnt_q != 2'd0);

  // Handshake: flush wins over accepting a new instruction.
  always_comb begin
    ms_valid_d = ms_valid_q;
    if (except_flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
  end

  // Read-data buffer: hold a response that arrived while WB was stalled.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_rdata_d = buf_rdata_q;
    if (except_flush || retire || load_en) begin
      buf_valid_d = 1'b0;
    end else if (resp_ok && ms_valid_q && ms_mem_req_q && !buf_valid_q && !ws_allowin) begin
      buf_valid_d = 1'b1;
      buf_rdata_d = data_sram_rdata;
    end
  end

  // Cancel counter: count requests orphaned by a flush, drain one per data_ok.
  always_comb begin
    cancel_inc = 3'd0;
    if (except_flush) begin
      cancel_inc = {2'b00, mem_pending} + {2'b00, es_req_fire};
    end
    cancel_nxt   = {1'b0, cancel_cnt_q} + cancel_inc - {2'b00, cancel_dec};
    cancel_cnt_d = cancel_nxt[1:0];
  end

  // Load data extraction and extension from the byte offset of the VA.
  always_comb begin
    ld_src = buf_valid_q ? buf_rdata_q : data_sram_rdata;
    case (ms_result_q[1:0])
      2'd0:    ld_byte = ld_src[7:0];
      2'd1:    ld_byte = ld_src[15:8];
      2'd2:    ld_byte = ld_src[23:16];
      default: ld_byte = ld_src[31:24];
    endcase
    ld_half = ms_result_q[1] ? ld_src[31:16] : ld_src[15:0];
    ld_data = ({32{ms_ld_op_q[LD_W]}}  & ld_src)
            | ({32{ms_ld_op_q[LD_H]}}  & {{16{ld_half[15]}}, ld_half})
            | ({32{ms_ld_op_q[LD_HU]}} & {16'd0, ld_half})
            | ({32{ms_ld_op_q[LD_B]}}  & {{24{ld_byte[7]}}, ld_byte})
            | ({32{ms_ld_op_q[LD_BU]}} & {24'd0, ld_byte});
    ms_final_result = ms_res_from_mem_q ? ld_data : ms_result_q;
  end

`ifdef MS_LOAD_FWD_EN
  // Load data may be forwarded to ID as soon as it is present in MEM.
  assign ms_fwd_ready = ms_valid_q & (~ms_res_from_mem_q | buf_valid_q | resp_ok);
`else
  // Loads are only forwarded once they reach WB.
  assign ms_fwd_ready = ms_valid_q & ~ms_res_from_mem_q;
`endif

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q        <= 1'b0;
      ms_pc_q           <= '0;
      ms_res_from_mem_q <= 1'b0;
      ms_rf_we_q        <= 1'b0;
      ms_rf_waddr_q     <= '0;
      ms_result_q       <= '0;
      ms_ld_op_q        <= '0;
      ms_mem_req_q      <= 1'b0;
      ms_except_q       <= '0;
      cancel_cnt_q      <= 2'd0;
      buf_valid_q       <= 1'b0;
      buf_rdata_q       <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      cancel_cnt_q <= cancel_cnt_d;
      buf_valid_q  <= buf_valid_d;
      buf_rdata_q  <= buf_rdata_d;
      if (load_en) begin
        ms_pc_q           <= es_pc;
        ms_res_from_mem_q <= es_res_from_mem;
        ms_rf_we_q        <= es_rf_we;
        ms_rf_waddr_q     <= es_rf_waddr;
        ms_result_q       <= es_result;
        ms_ld_op_q        <= es_ld_op;
        ms_mem_req_q      <= es_mem_req;
        ms_except_q       <= es_except;
      end
    end
  end

  // At most one request in MEM and one in EX can be orphaned at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cancel_nxt <= 3'd2)
        else $error("mem_stage: cancel counter overflow");
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a scoreboard; a negedge monitor pops
// expected WB transfers and compares them against the DUT.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_res_from_mem;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_result;
  logic [4:0]  es_ld_op;
  logic        es_mem_req;
  logic [15:0] es_except;
  logic        es_req_fire;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        except_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_final_result;
  logic [15:0] ms_except;
  logic        ms_ex;
  logic        ms_fwd_ready;

  localparam logic [4:0]  OP_W  = 5'b10000;
  localparam logic [4:0]  OP_H  = 5'b01000;
  localparam logic [4:0]  OP_HU = 5'b00100;
  localparam logic [4:0]  OP_B  = 5'b00010;
  localparam logic [4:0]  OP_BU = 5'b00001;
  localparam logic [31:0] IDLE_RDATA = 32'hDEAD_BEEF;

`ifdef MS_LOAD_FWD_EN
  localparam logic FWD_ON_RESP = 1'b1;
`else
  localparam logic FWD_ON_RESP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] res;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [15:0] exc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  mem_stage #(.EXC_W(16), .LDOP_W(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_res_from_mem   (es_res_from_mem),
    .es_rf_we          (es_rf_we),
    .es_rf_waddr       (es_rf_waddr),
    .es_result         (es_result),
    .es_ld_op          (es_ld_op),
    .es_mem_req        (es_mem_req),
    .es_except         (es_except),
    .es_req_fire       (es_req_fire),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .except_flush      (except_flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_rf_we          (ms_rf_we),
    .ms_rf_waddr       (ms_rf_waddr),
    .ms_final_result   (ms_final_result),
    .ms_except         (ms_except),
    .ms_ex             (ms_ex),
    .ms_fwd_ready      (ms_fwd_ready)
  );

  always #5 clk = ~clk;

  // Monitor: every WB transfer must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_transfer: got pc=%h res=%h, required no transfer", ms_pc, ms_final_result);
      end else begin
        e = sb.pop_front();
        if (ms_pc !== e.pc || ms_final_result !== e.res || ms_rf_we !== e.rf_we ||
            ms_rf_waddr !== e.waddr || ms_except !== e.exc) begin
          n_err++;
          $display("FAIL transfer: got pc=%h res=%h we=%b wa=%0d exc=%h, required pc=%h res=%h we=%b wa=%0d exc=%h",
                   ms_pc, ms_final_result, ms_rf_we, ms_rf_waddr, ms_except,
                   e.pc, e.res, e.rf_we, e.waddr, e.exc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_xfer(input logic [31:0] pc, input logic [31:0] res, input logic we,
                             input logic [4:0] wa, input logic [15:0] exc);
    exp_t e;
    e.pc = pc; e.res = res; e.rf_we = we; e.waddr = wa; e.exc = exc;
    sb.push_back(e);
  endtask

  // Present one instruction from EX and hold it until MEM accepts it.
  // Returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] pc, input logic rfm, input logic we, input logic [4:0] wa,
                      input logic [31:0] res, input logic [4:0] op, input logic mreq,
                      input logic [15:0] exc);
    bit ok = 0;
    es_to_ms_valid = 1'b1;
    es_pc = pc; es_res_from_mem = rfm; es_rf_we = we; es_rf_waddr = wa;
    es_result = res; es_ld_op = op; es_mem_req = mreq; es_except = exc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ms_allowin) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: got ms_allowin=0 for 50 cycles, required 1 (pc=%h)", pc);
    end
    @(posedge clk); #1;
    es_to_ms_valid = 1'b0;
  endtask

  // One-cycle data_ok; checks ready_go (via ms_to_ws_valid) during the response.
  task automatic resp(input logic [31:0] rd, input logic exp_valid, input string name);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    #1;
    check(name, {31'd0, ms_to_ws_valid}, {31'd0, exp_valid});
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = IDLE_RDATA;
  endtask

  initial begin
    reset = 1'b1;
    es_to_ms_valid = 0; es_pc = 0; es_res_from_mem = 0; es_rf_we = 0; es_rf_waddr = 0;
    es_result = 0; es_ld_op = 0; es_mem_req = 0; es_except = 0; es_req_fire = 0;
    data_sram_data_ok = 0; data_sram_rdata = IDLE_RDATA; ws_allowin = 1; except_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_allowin",   {31'd0, ms_allowin},     32'd1);
    check("rst_valid",     {31'd0, ms_to_ws_valid}, 32'd0);
    check("rst_pc",        ms_pc,                   32'd0);
    check("rst_final",     ms_final_result,         32'd0);
    check("rst_except",    {16'd0, ms_except},      32'd0);
    check("rst_rf_we",     {31'd0, ms_rf_we},       32'd0);
    check("rst_fwd",       {31'd0, ms_fwd_ready},   32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ALU op passes straight through with no wait
    expect_xfer(32'h100, 32'h1234, 1'b1, 5'd5, 16'h0);
    send(32'h100, 1'b0, 1'b1, 5'd5, 32'h1234, 5'd0, 1'b0, 16'h0);
    check("alu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    check("alu_fwd",   {31'd0, ms_fwd_ready},   32'd1);
    @(posedge clk); #1;
    check("alu_gone",  {31'd0, ms_to_ws_valid}, 32'd0);

    // ld_b at off=3, response two cycles after entry
    expect_xfer(32'h104, 32'hFFFF_FF80, 1'b1, 5'd6, 16'h0);
    send(32'h104, 1'b1, 1'b1, 5'd6, 32'h0000_1003, OP_B, 1'b1, 16'h0);
    check("ldb_wait",     {31'd0, ms_to_ws_valid}, 32'd0);
    check("ldb_fwd_wait", {31'd0, ms_fwd_ready},   32'd0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80AA_BBCC;
    #1;
    check("ldb_fwd_resp", {31'd0, ms_fwd_ready},   {31'd0, FWD_ON_RESP});
    check("ldb_final",    ms_final_result,         32'hFFFF_FF80);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0; data_sram_rdata = IDLE_RDATA;

    // ld_bu same byte, zero-extended
    expect_xfer(32'h108, 32'h0000_0080, 1'b1, 5'd7, 16'h0);
    send(32'h108, 1'b1, 1'b1, 5'd7, 32'h0000_1003, OP_BU, 1'b1, 16'h0);
    resp(32'h80AA_BBCC, 1'b1, "ldbu_ready");

    // ld_hu upper half, zero-extended
    expect_xfer(32'h10C, 32'h0000_9876, 1'b1, 5'd8, 16'h0);
    send(32'h10C, 1'b1, 1'b1, 5'd8, 32'h0000_2002, OP_HU, 1'b1, 16'h0);
    resp(32'h9876_5432, 1'b1, "ldhu_ready");

    // ld_h off=2 while WB stalls 3 cycles: data buffered, one transfer
    ws_allowin = 1'b0;
    expect_xfer(32'h110, 32'hFFFF_8001, 1'b1, 5'd9, 16'h0);
    send(32'h110, 1'b1, 1'b1, 5'd9, 32'h0000_3002, OP_H, 1'b1, 16'h0);
    resp(32'h8001_7FFF, 1'b1, "ldh_resp_ready");
    check("ldh_buf_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    check("ldh_buf_final", ms_final_result,         32'hFFFF_8001);
    repeat (2) @(posedge clk);
    #1;
    ws_allowin = 1'b1;
    @(posedge clk); #1;
    check("ldh_one_xfer", {31'd0, ms_to_ws_valid}, 32'd0);

    // Flush with a load waiting in MEM and an EX request firing: two stale responses
    send(32'h200, 1'b1, 1'b1, 5'd10, 32'h0000_4000, OP_W, 1'b1, 16'h0);
    except_flush = 1'b1; es_req_fire = 1'b1;
    #1;
    check("flush_no_xfer", {31'd0, ms_to_ws_valid}, 32'd0);
    @(posedge clk); #1;
    except_flush = 1'b0; es_req_fire = 1'b0;
    expect_xfer(32'h204, 32'h3333_3333, 1'b1, 5'd11, 16'h0);
    send(32'h204, 1'b1, 1'b1, 5'd11, 32'h0000_5000, OP_W, 1'b1, 16'h0);
    resp(32'h1111_1111, 1'b0, "cancel_drop1");
    resp(32'h2222_2222, 1'b0, "cancel_drop2");
    resp(32'h3333_3333, 1'b1, "cancel_accept");

    // ALE entry: retires immediately, no regfile write, no response awaited
    expect_xfer(32'h300, IDLE_RDATA, 1'b0, 5'd12, 16'h8000);
    send(32'h300, 1'b1, 1'b1, 5'd12, 32'h0000_6001, OP_W, 1'b0, 16'h8000);
    check("ale_ex",    {31'd0, ms_ex},          32'd1);
    check("ale_rf_we", {31'd0, ms_rf_we},       32'd0);
    check("ale_ready", {31'd0, ms_to_ws_valid}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: got %0d outstanding expected transfers, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
